fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first byte address fetched after reset.
REQ-002 Parameter IMEM_AW, default 5, imem word-address width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 resets the block immediately.
REQ-005 imem_address  output  IMEM_AW  word address to imem, equal to pc[IMEM_AW+1:2].
REQ-006 imem_rw  output  1  imem mode; constant 1 (read); the block never writes.
REQ-007 imem_data_in  output  32  imem write data; constant 0.
REQ-008 imem_data_out  input  32  imem read data, valid one cycle after the address is issued.
REQ-009 instr_valid  output  1  buffer head holds a valid instruction.
REQ-010 instr  output  32  instruction at buffer head.
REQ-011 instr_pc  output  32  byte address of instr.
REQ-012 instr_ready  input  1  consumer accepts head when instr_valid && instr_ready.
REQ-013 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-014 redirect_pc  input  32  new fetch byte address.
REQ-015 fetch_fault  output  1  misaligned redirect detected (FETCH_ALIGN_CHK_EN only; else constant 0).

Function
REQ-016 States: IDLE (one cycle after reset release), RUN, HALT (FETCH_ALIGN_CHK_EN only); IDLE->RUN unconditionally.
REQ-017 2-entry instruction FIFO holding {instr, instr_pc}; head drives instr/instr_pc.
REQ-018 In RUN, a read issues in a cycle iff (stored entries + in-flight reads) < 2 and no redirect; issue sets in-flight flag, records pc, pc <= pc+4.
REQ-019 Response captured into FIFO the cycle after issue with recorded pc; latency issue-to-instr_valid = 2 cycles from empty.
REQ-020 Simultaneous pop and capture with FIFO full-by-count: allowed; occupancy stays constant, order preserved.
REQ-021 Sustained throughput with instr_ready=1: one instruction per cycle after initial latency.
REQ-022 instr_ready=0: instr/instr_pc held stable while instr_valid=1; issue stops when 2 entries committed.
REQ-023 pc is 32-bit, wraps 32'hFFFF_FFFC -> 0; imem_address wraps naturally at 2^IMEM_AW words.
REQ-024 Redirect has top priority: FIFO cleared, in-flight response discarded, no issue that cycle, pc <= redirect_pc; fetch resumes next cycle.
REQ-025 Redirect coincident with pop or capture: redirect wins; popped instruction counts as consumed, captured one is dropped.
REQ-026 imem_address holds last issued value when not issuing.

Reset
REQ-027 On reset=0: state IDLE, pc=RESET_PC, FIFO empty, in-flight clear, instr_valid=0, instr=0, instr_pc=0, fetch_fault=0, imem_address=RESET_PC[IMEM_AW+1:2].
REQ-028 Reset mid-operation discards FIFO and in-flight data; no instr_valid pulse until new fetch completes.

Configuration
REQ-029 Macro FETCH_ALIGN_CHK_EN defined: redirect with redirect_pc[1:0]!=0 sets fetch_fault=1, clears FIFO, enters HALT; HALT issues nothing, ignores redirects, exits only by reset.
REQ-030 Macro undefined: redirect_pc[1:0] ignored (forced 0), fetch_fault tied 0, no HALT state.

Structure
REQ-031 Shared package holds state encoding (IDLE/RUN/HALT), FIFO depth 2, and instruction-word width 32.
REQ-032 One sub-module fetch_buf: 2-entry FIFO of {instr, pc} with push/pop/flush and count.

Verification
REQ-033 Reset release, imem preloaded word1=32'h0016_8693, instr_ready=1 -> instr_valid first at cycle 3, instr_pc=0, then pc 4, 8... one per cycle.
REQ-034 instr_ready=0 for 5 cycles after first valid -> instr/instr_pc stable, exactly 2 entries, no lost or duplicated instruction on release.
REQ-035 Redirect to 32'h0000_0040 while FIFO full -> FIFO flushed, next instr_pc=32'h40, word 16 read (IMEM_AW=5 wraps: 0x80 -> word 0).
REQ-036 Reset asserted mid-stream for 1 cycle -> instr_valid=0 immediately, restart at RESET_PC.
REQ-037 With FETCH_ALIGN_CHK_EN, redirect to 32'h0000_0006 -> fetch_fault=1, no further issues, later redirect ignored; without macro, fetch at 32'h4.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state encoding, buffer depth and instruction width for the fetch unit
package fetch_unit_pkg;
   localparam int FIFO_DEPTH = 2;
   localparam int INSTR_W    = 32;
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [31:0]        pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem, instruction-delivery and redirect signals of the fetch unit
interface fetch_unit_if #(parameter int IMEM_AW = 5);
   logic [IMEM_AW-1:0] imem_address;
   logic               imem_rw;
   logic [31:0]        imem_data_in;
   logic [31:0]        imem_data_out;
   logic               instr_valid;
   logic [31:0]        instr;
   logic [31:0]        instr_pc;
   logic               instr_ready;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic               fetch_fault;
   modport master (
      output imem_address, imem_rw, imem_data_in, instr_valid, instr, instr_pc, fetch_fault,
      input  imem_data_out, instr_ready, redirect_valid, redirect_pc
   );
   modport slave (
      input  imem_address, imem_rw, imem_data_in, instr_valid, instr, instr_pc, fetch_fault,
      output imem_data_out, instr_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO of {instr, pc}; flush beats push/pop, push into a full buffer only with a pop
module fetch_buf
   import fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output fetch_entry_t dout,
   output logic [1:0]   count
);
   fetch_entry_t mem_q [FIFO_DEPTH];
   fetch_entry_t mem_d [FIFO_DEPTH];
   logic       rd_q, rd_d, wr, do_push, do_pop;
   logic [1:0] cnt_q, cnt_d;
   // next pointer, count and storage; write slot is head+count modulo depth
   always_comb begin
      do_pop  = pop && cnt_q != 2'd0;
      do_push = push && (cnt_q != 2'(FIFO_DEPTH) || do_pop);
      wr      = rd_q ^ cnt_q[0];
      mem_d   = mem_q;
      if (do_push) mem_d[wr] = din;
      rd_d    = flush ? 1'b0 : rd_q ^ do_pop;
      cnt_d   = flush ? 2'd0 : cnt_q + 2'(do_push) - 2'(do_pop);
   end
   // buffer state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q <= '{default: '0};
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   assign dout  = mem_q[rd_q];
   assign count = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: prefetches instructions from a 1-cycle imem into a 2-entry buffer; FETCH_ALIGN_CHK_EN halts on misaligned redirect
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 5
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);
   state_t             state_q, state_d;
   logic [31:0]        pc_q, pc_d, ipc_q, ipc_d, tgt;
   logic [IMEM_AW-1:0] addr_q, addr_d;
   logic               infl_q, infl_d, fault_q, fault_d;
   logic               pop, redir, misal, issue, capture;
   logic [1:0]         count;
   logic [2:0]         occ;
   fetch_entry_t       din, head;
   assign din = {bus.imem_data_out, ipc_q};
   fetch_buf u_buf (
      .clk   (clk),
      .reset (reset),
      .push  (capture),
      .pop   (pop),
      .flush (redir),
      .din   (din),
      .dout  (head),
      .count (count)
   );
   // issue control counts this cycle's pop so a steady consumer gets one instruction per cycle
   always_comb begin
      pop   = count != 2'd0 && bus.instr_ready;
      tgt   = bus.redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_ALIGN_CHK_EN
      misal = |bus.redirect_pc[1:0];
`else
      misal = 1'b0;
`endif
      redir   = bus.redirect_valid && state_q != HALT;
      occ     = 3'(count) - 3'(pop) + 3'(infl_q);
      issue   = state_q == RUN && !redir && occ < 3'd2;
      capture = infl_q && !redir;
      state_d = (redir && misal) ? HALT : (state_q == IDLE) ? RUN : state_q;
      pc_d    = redir ? tgt : issue ? pc_q + 32'd4 : pc_q;
      ipc_d   = issue ? pc_q : ipc_q;
      addr_d  = issue ? pc_q[IMEM_AW+1:2] : addr_q;
      infl_d  = issue;
      fault_d = fault_q || (redir && misal);
   end
   // control and fetch-address registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         ipc_q   <= '0;
         addr_q  <= RESET_PC[IMEM_AW+1:2];
         infl_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ipc_q   <= ipc_d;
         addr_q  <= addr_d;
         infl_q  <= infl_d;
         fault_q <= fault_d;
      end
   end
   assign bus.imem_address = addr_d;
   assign bus.imem_rw      = 1'b1;
   assign bus.imem_data_in = '0;
   assign bus.instr_valid  = count != 2'd0;
   assign bus.instr        = head.instr;
   assign bus.instr_pc     = head.pc;
   assign bus.fetch_fault  = fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus checked against an in-order fetch-stream model
module tb_fetch_unit;
   logic clk = 1'b0;
   logic reset;
   logic [31:0] mem [32];
   int n_cmp = 0;
   int n_bad = 0;
   int n;
   logic [31:0] p0, a0;
   logic [31:0] exp_pc, hold_i, hold_p;
   logic hold, was_redir, halted, redir, misal;

   fetch_unit_if #(.IMEM_AW(5)) bus ();
   fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // synchronous-read instruction memory
   always @(posedge clk) bus.imem_data_out <= mem[bus.imem_address];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_valid(output int cnt);
      cnt = 0;
      while (!bus.instr_valid && cnt < 12) begin
         cyc(1);
         cnt++;
      end
      chk("wait_valid", 32'(bus.instr_valid), 32'd1);
   endtask

   // model: consumed instructions must be the word stream starting at the last fetch target
   always @(negedge clk) begin
      if (!reset) begin
         exp_pc = 32'h0; hold = 1'b0; was_redir = 1'b0; halted = 1'b0;
      end else begin
         chk("imem_rw", 32'(bus.imem_rw), 32'd1);
         chk("imem_data_in", bus.imem_data_in, 32'd0);
         chk("fault", 32'(bus.fetch_fault), 32'(halted));
         if (was_redir || halted) chk("flushed_valid", 32'(bus.instr_valid), 32'd0);
         if (hold) begin
            chk("hold_valid", 32'(bus.instr_valid), 32'd1);
            chk("hold_instr", bus.instr, hold_i);
            chk("hold_pc", bus.instr_pc, hold_p);
         end
         if (bus.instr_valid && bus.instr_ready) begin
            chk("pop_pc", bus.instr_pc, exp_pc);
            chk("pop_instr", bus.instr, mem[exp_pc[6:2]]);
            exp_pc = exp_pc + 32'd4;
         end
         redir = bus.redirect_valid && !halted;
`ifdef FETCH_ALIGN_CHK_EN
         misal = |bus.redirect_pc[1:0];
`else
         misal = 1'b0;
`endif
         hold = bus.instr_valid && !bus.instr_ready && !redir;
         hold_i = bus.instr;
         hold_p = bus.instr_pc;
         was_redir = redir;
         if (redir) begin
            if (misal) halted = 1'b1;
            else exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
         end
      end
   end

   initial begin
      reset = 1'b0;
      bus.instr_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      mem[1] = 32'h0016_8693;
      cyc(3);
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_instr", bus.instr, 32'd0);
      chk("rst_pc", bus.instr_pc, 32'd0);
      chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
      chk("rst_addr", 32'(bus.imem_address), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      bus.instr_ready = 1'b1;
      n = 0;
      while (!bus.instr_valid && n < 10) begin
         cyc(1);
         n++;
      end
      chk("first_latency", n, 32'd3);
      chk("first_pc", bus.instr_pc, 32'h0);
      cyc(1);
      chk("second_pc", bus.instr_pc, 32'h4);
      chk("second_instr", bus.instr, 32'h0016_8693);
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         chk("stream_valid", 32'(bus.instr_valid), 32'd1);
         chk("stream_pc", bus.instr_pc, 32'h8 + 32'(i) * 4);
      end
      bus.instr_ready = 1'b0;
      p0 = bus.instr_pc;
      cyc(5);
      chk("stall_pc", bus.instr_pc, p0);
      bus.instr_ready = 1'b1;
      cyc(1);
      chk("release_pc1", bus.instr_pc, p0 + 32'd4);
      cyc(1);
      chk("release_pc2", bus.instr_pc, p0 + 32'd8);
      bus.instr_ready = 1'b0;
      cyc(4);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_0040;
      cyc(1);
      bus.redirect_valid = 1'b0;
      bus.instr_ready = 1'b1;
      chk("redirect_flush", 32'(bus.instr_valid), 32'd0);
      wait_valid(n);
      chk("redirect_pc", bus.instr_pc, 32'h40);
      chk("redirect_instr", bus.instr, mem[16]);
      cyc(20);
      for (int i = 0; i < 2000; i++) begin
         bus.instr_ready = $urandom_range(0, 3) != 0;
         bus.redirect_valid = $urandom_range(0, 15) == 0;
         bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
         cyc(1);
      end
      bus.redirect_valid = 1'b0;
      bus.instr_ready = 1'b1;
      cyc(10);
      reset = 1'b0;
      #1;
      chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
      chk("midrst_addr", 32'(bus.imem_address), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      n = 0;
      while (!bus.instr_valid && n < 10) begin
         cyc(1);
         n++;
      end
      chk("restart_latency", n, 32'd3);
      chk("restart_pc", bus.instr_pc, 32'h0);
      cyc(5);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_0006;
      cyc(1);
      bus.redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      cyc(4);
      chk("halt_fault", 32'(bus.fetch_fault), 32'd1);
      chk("halt_valid", 32'(bus.instr_valid), 32'd0);
      a0 = 32'(bus.imem_address);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_0010;
      cyc(1);
      bus.redirect_valid = 1'b0;
      cyc(6);
      chk("halt_ignore_valid", 32'(bus.instr_valid), 32'd0);
      chk("halt_ignore_addr", 32'(bus.imem_address), a0);
      chk("halt_ignore_fault", 32'(bus.fetch_fault), 32'd1);
`else
      wait_valid(n);
      chk("misalign_pc", bus.instr_pc, 32'h4);
      chk("misalign_fault", 32'(bus.fetch_fault), 32'd0);
      cyc(5);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
